alu_arbiter_rr: RTL

Two-port round-robin arbiter and sequencer for the shared 16-bit `ALU` (opcode/Funksioni/a/b in, REZULTATI/cout out).
- Accepts requests from two independent requesters over valid/ready handshakes, drives the combinational ALU from registered operands, and waits an extra settle period for multiply.
- Returns each result, with its carry, to the issuing requester over a second valid/ready handshake.
- Sits between instruction-issue logic and the single ALU instance, so two masters can share one datapath.

---
 rtl/alu_arbiter_rr.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter_rr.sv
// alu_arbiter_rr: two-port round-robin front end for a single shared ALU.
// Each requester uses a valid/ready request channel and a valid/ready
// response channel. A transfer happens on a rising edge where both valid
// and ready are high; the sender holds its payload stable until then and
// may withdraw valid before acceptance. ALU inputs come from registers so
// the ALU sees stable operands for the whole EXEC phase. Multiply gets
// MUL_WAIT extra cycles to settle.
module alu_arbiter_rr #(
    parameter int WIDTH    = 16,
    parameter int MUL_WAIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [1:0]       r0_opcode,
    input  logic [4:0]       r0_funksioni,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rvalid,
    input  logic             r0_rready,
    output logic [WIDTH-1:0] r0_rezultati,
    output logic             r0_cout,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [1:0]       r1_opcode,
    input  logic [4:0]       r1_funksioni,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rvalid,
    input  logic             r1_rready,
    output logic [WIDTH-1:0] r1_rezultati,
    output logic             r1_cout,
    output logic [1:0]       alu_opcode,
    output logic [4:0]       alu_funksioni,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_rezultati,
    input  logic             alu_cout,
    output logic             busy,
    output logic             grant_id
);

    localparam int CW = (MUL_WAIT > 0) ? $clog2(MUL_WAIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             sel;
    logic             in_idle;
    logic             accept;
    logic             is_mul;
    logic             resp_taken;
    logic [CW-1:0]    wait_cnt;
    logic [WIDTH-1:0] result;
    logic             result_cout;
    logic [1:0]       req_opcode;
    logic [4:0]       req_funksioni;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        sel = 1'b0;
        if (r0_valid && !r1_valid) begin
            sel = 1'b0;
        end else if (r1_valid && !r0_valid) begin
            sel = 1'b1;
        end else if (r0_valid && r1_valid) begin
            sel = ~last_grant;
        end
    end

    // Ready is withheld during reset so nothing is accepted on the reset edge.
    assign in_idle  = (state == IDLE) && !reset;
    assign r0_ready = in_idle && r0_valid && !sel;
    assign r1_ready = in_idle && r1_valid && sel;
    assign accept   = (r0_valid && r0_ready) || (r1_valid && r1_ready);

    assign req_opcode    = sel ? r1_opcode    : r0_opcode;
    assign req_funksioni = sel ? r1_funksioni : r0_funksioni;
    assign req_a         = sel ? r1_a         : r0_a;
    assign req_b         = sel ? r1_b         : r0_b;
    assign is_mul        = (req_opcode == 2'b00) && (req_funksioni == 5'b10000);

    assign resp_taken = grant_id ? r1_rready : r0_rready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, wait out the count in EXEC, hand off in RESP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = EXEC;
            EXEC: if (wait_cnt == '0) state_next = RESP;
            RESP: if (resp_taken) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, grant bookkeeping, settle counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant    <= 1'b1;
            grant_id      <= 1'b0;
            wait_cnt      <= '0;
            alu_opcode    <= '0;
            alu_funksioni <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            result        <= '0;
            result_cout   <= 1'b0;
        end else begin
            if (accept) begin
                alu_opcode    <= req_opcode;
                alu_funksioni <= req_funksioni;
                alu_a         <= req_a;
                alu_b         <= req_b;
                grant_id      <= sel;
                last_grant    <= sel;
                wait_cnt      <= is_mul ? CW'(MUL_WAIT) : '0;
            end
            if (state == EXEC) begin
                if (wait_cnt != '0) begin
                    wait_cnt <= wait_cnt - CW'(1);
                end else begin
                    result      <= alu_rezultati;
                    result_cout <= alu_cout;
                end
            end
        end
    end

    assign r0_rvalid    = (state == RESP) && !grant_id && !reset;
    assign r1_rvalid    = (state == RESP) &&  grant_id && !reset;
    assign r0_rezultati = result;
    assign r1_rezultati = result;
    assign r0_cout      = result_cout;
    assign r1_cout      = result_cout;
    assign busy         = (state != IDLE);

endmodule
